// File: rtl/pattern_timer_fsm_pkg.sv
// timer_pkg: shared definitions for the pattern timer.
//   state_e     - FSM state encoding (2 bits).
//   unit_cnt_w  - width of the per-unit prescaler for a given UNIT_CYCLES
//                 ($clog2 of the cycle count, never below 1 bit).
package timer_pkg;

  typedef enum logic [1:0] {
    SEARCH   = 2'd0,
    SHIFT    = 2'd1,
    COUNT    = 2'd2,
    WAIT_ACK = 2'd3
  } state_e;

  function automatic int unit_cnt_w(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/pattern_timer_fsm_counter.sv
// unit_down_counter: loadable down-counter used as the per-unit prescaler.
//   i_clk    - clock, rising edge
//   i_rst_n  - asynchronous active-low reset (clears the value)
//   i_load   - load LOAD_VALUE (has priority over i_en)
//   i_en     - decrement by one
//   o_zero   - value is zero
//   o_value  - current value
module unit_down_counter #(
  parameter int W          = 10,
  parameter int LOAD_VALUE = 999
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_en,
  output logic         o_zero,
  output logic [W-1:0] o_value
);

  logic [W-1:0] r_value;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= W'(LOAD_VALUE);
    end else if (i_en) begin
      r_value <= r_value - W'(1);
    end
  end

  assign o_zero  = (r_value == '0);
  assign o_value = r_value;

endmodule

// File: rtl/pattern_timer_fsm.sv
// pattern_timer_fsm: hunts a serial stream for a start pattern, shifts in a
// DELAY_W-bit delay (MSB first), counts (delay+1)*UNIT_CYCLES clocks, then
// raises done until acknowledged (or pulses it once with AUTO_REARM=1).
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset
//   data     - serial input, sampled every rising edge
//   ack      - host acknowledge of done (only honoured in WAIT_ACK)
//   abort    - cancels SHIFT/COUNT, synchronous
//   count    - remaining whole units while counting, else 0
//   counting - high throughout COUNT
//   done     - high in WAIT_ACK; single-cycle pulse when AUTO_REARM=1
module pattern_timer_fsm
  import timer_pkg::*;
#(
  parameter int                 PAT_LEN     = 4,
  parameter logic [PAT_LEN-1:0] PATTERN     = 4'b1101,
  parameter int                 DELAY_W     = 4,
  parameter int                 UNIT_CYCLES = 1000,
  parameter bit                 AUTO_REARM  = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               data,
  input  logic               ack,
  input  logic               abort,
  output logic [DELAY_W-1:0] count,
  output logic               counting,
  output logic               done
);

  localparam int UCW    = unit_cnt_w(UNIT_CYCLES);
  localparam int FILL_W = $clog2(PAT_LEN);
  localparam int BIT_W  = $clog2(DELAY_W + 1);

  state_e             r_state;
  logic [PAT_LEN-2:0] r_hist;
  logic [FILL_W-1:0]  r_fill;
  logic [DELAY_W-1:0] r_delay;
  logic [DELAY_W-1:0] r_count;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic               r_done;

  logic               w_unit_zero;
  logic [UCW-1:0]     w_unit_value;
  logic               w_unit_load;
  logic               w_unit_en;
  logic [PAT_LEN-1:0] w_window;
  logic               w_match;
  logic [DELAY_W-1:0] w_delay_next;
  logic               w_last_bit;

  assign w_window     = {r_hist, data};
  // r_fill counts bits seen since entering SEARCH, so a pattern can only be
  // built from bits that arrived after re-entry (matters for patterns with
  // leading zeros, which a cleared history would otherwise half-satisfy).
  assign w_match      = (w_window == PATTERN) && (r_fill == FILL_W'(PAT_LEN - 1));
  assign w_delay_next = DELAY_W'({r_delay, data});
  assign w_last_bit   = (r_bit_cnt == BIT_W'(DELAY_W - 1));

  // Prescaler loads on entry to COUNT and on every unit boundary that still
  // has whole units left; otherwise it free-runs down to zero while counting.
  assign w_unit_load = !abort &&
                       ((r_state == SHIFT && w_last_bit) ||
                        (r_state == COUNT && w_unit_zero && r_count != '0));
  assign w_unit_en   = (r_state == COUNT) && (w_unit_value != '0);

  unit_down_counter #(
    .W          (UCW),
    .LOAD_VALUE (UNIT_CYCLES - 1)
  ) u_unit (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_load  (w_unit_load),
    .i_en    (w_unit_en),
    .o_zero  (w_unit_zero),
    .o_value (w_unit_value)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= SEARCH;
      r_hist    <= '0;
      r_fill    <= '0;
      r_delay   <= '0;
      r_count   <= '0;
      r_bit_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        SEARCH: begin
          if (w_match) begin
            r_state   <= SHIFT;
            r_delay   <= '0;
            r_bit_cnt <= '0;
          end else begin
            r_hist <= w_window[PAT_LEN-2:0];
            if (r_fill != FILL_W'(PAT_LEN - 1)) r_fill <= r_fill + FILL_W'(1);
          end
        end
        SHIFT: begin
          if (abort) begin
            r_state <= SEARCH;
            r_hist  <= '0;
            r_fill  <= '0;
          end else begin
            r_delay   <= w_delay_next;
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            if (w_last_bit) begin
              r_state <= COUNT;
              r_count <= w_delay_next;
            end
          end
        end
        COUNT: begin
          if (abort) begin
            r_state <= SEARCH;
            r_count <= '0;
            r_hist  <= '0;
            r_fill  <= '0;
          end else if (w_unit_zero) begin
            if (r_count != '0) begin
              r_count <= r_count - DELAY_W'(1);
            end else begin
              r_done <= 1'b1;
              if (AUTO_REARM) begin
                r_state <= SEARCH;
                r_hist  <= '0;
                r_fill  <= '0;
              end else begin
                r_state <= WAIT_ACK;
              end
            end
          end
        end
        WAIT_ACK: begin
          if (ack) begin
            r_state <= SEARCH;
            r_hist  <= '0;
            r_fill  <= '0;
          end else begin
            r_done <= 1'b1;
          end
        end
        default: r_state <= SEARCH;
      endcase
    end
  end

  assign count    = r_count;
  assign counting = (r_state == COUNT);
  assign done     = r_done;

endmodule

// File: tb/tb_pattern_timer_fsm.sv
module tb_pattern_timer_fsm;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b1;
  logic       data    = 1'b0;
  logic       ack     = 1'b0;
  logic       abort   = 1'b0;
  logic [3:0] count0;
  logic       counting0, done0;
  logic [2:0] count1;
  logic       counting1, done1;

  int n_checks = 0;
  int n_errors = 0;
  int len0, len1, dcyc0, dcyc1;

  // Per-instance configuration of the reference model.
  int cfg_pl [2] = '{4, 5};
  int cfg_pat[2] = '{13, 22};
  int cfg_dw [2] = '{4, 3};
  int cfg_u  [2] = '{1000, 4};
  int cfg_ar [2] = '{0, 1};

  // Reference model: phase 0=hunting, 1=reading delay, 2=timing, 3=holding done.
  // Timing is kept as one total-cycles-remaining number; the unit count is derived.
  int m_phase[2], m_hist[2], m_nhist[2], m_delay[2], m_nbits[2], m_remain[2];
  bit m_done [2];

  always #5 clk = ~clk;

  pattern_timer_fsm u_dut0 (
    .clk(clk), .reset_n(reset_n), .data(data), .ack(ack), .abort(abort),
    .count(count0), .counting(counting0), .done(done0)
  );

  pattern_timer_fsm #(
    .PAT_LEN(5), .PATTERN(5'b10110), .DELAY_W(3), .UNIT_CYCLES(4), .AUTO_REARM(1'b1)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .data(data), .ack(ack), .abort(abort),
    .count(count1), .counting(counting1), .done(done1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_count(input int i);
    return (m_phase[i] == 2) ? (m_remain[i] - 1) / cfg_u[i] : 0;
  endfunction

  task automatic enter_search(input int i);
    m_phase[i] = 0;
    m_hist[i]  = 0;
    m_nhist[i] = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      enter_search(i);
      m_delay[i]  = 0;
      m_nbits[i]  = 0;
      m_remain[i] = 0;
      m_done[i]   = 0;
    end
  endtask

  task automatic model_edge(input int i, input bit d, input bit a, input bit ab);
    if (cfg_ar[i] != 0) m_done[i] = 0;
    case (m_phase[i])
      0: begin
        m_hist[i] = ((m_hist[i] << 1) | int'(d)) & ((1 << cfg_pl[i]) - 1);
        if (m_nhist[i] < cfg_pl[i]) m_nhist[i]++;
        if (m_nhist[i] == cfg_pl[i] && m_hist[i] == cfg_pat[i]) begin
          m_phase[i] = 1;
          m_delay[i] = 0;
          m_nbits[i] = 0;
        end
      end
      1: begin
        if (ab) enter_search(i);
        else begin
          m_delay[i] = m_delay[i] * 2 + int'(d);
          m_nbits[i]++;
          if (m_nbits[i] == cfg_dw[i]) begin
            m_phase[i]  = 2;
            m_remain[i] = (m_delay[i] + 1) * cfg_u[i];
          end
        end
      end
      2: begin
        if (ab) enter_search(i);
        else begin
          m_remain[i]--;
          if (m_remain[i] == 0) begin
            m_done[i] = 1;
            if (cfg_ar[i] != 0) enter_search(i);
            else m_phase[i] = 3;
          end
        end
      end
      default: begin
        if (a) begin
          enter_search(i);
          m_done[i] = 0;
        end
      end
    endcase
  endtask

  task automatic compare();
    chk("count0",    int'(count0),    exp_count(0));
    chk("counting0", int'(counting0), int'(m_phase[0] == 2));
    chk("done0",     int'(done0),     int'(m_done[0]));
    chk("count1",    int'(count1),    exp_count(1));
    chk("counting1", int'(counting1), int'(m_phase[1] == 2));
    chk("done1",     int'(done1),     int'(m_done[1]));
  endtask

  // Drive inputs on the falling edge, advance model on the rising edge,
  // compare on the next falling edge.
  task automatic step(input logic d, input logic a, input logic ab);
    data  = d;
    ack   = a;
    abort = ab;
    @(posedge clk);
    model_edge(0, d, a, ab);
    model_edge(1, d, a, ab);
    @(negedge clk);
    compare();
    if (counting0) len0++;
    if (counting1) len1++;
    if (done0) dcyc0++;
    if (done1) dcyc1++;
  endtask

  task automatic send(input logic [15:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) step(v[k], 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_count0"},    int'(count0),    0);
    chk({tag, "_counting0"}, int'(counting0), 0);
    chk({tag, "_done0"},     int'(done0),     0);
    chk({tag, "_count1"},    int'(count1),    0);
    chk({tag, "_counting1"}, int'(counting1), 0);
    chk({tag, "_done1"},     int'(done1),     0);
  endtask

  initial begin
    // Power-on reset.
    #1 reset_n = 1'b0;
    model_reset();
    #1 chk_all_zero("rst");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Default flow: 1101 + delay 5.
    len0 = 0;
    send(16'h00D5, 8);
    chk("cnt_rise", int'(counting0), 1);
    chk("cnt_val5", int'(count0), 5);
    idle(6005);
    chk("len_d5", len0, 6000);
    chk("done_set", int'(done0), 1);
    idle(400);
    chk("done_hold", int'(done0), 1);
    step(1'b0, 1'b1, 1'b0);
    chk("done_clr", int'(done0), 0);

    // Overlapping prefix, delay 0; abort while holding done is ignored.
    len0 = 0;
    send(16'h001D, 5);
    send(16'h0000, 4);
    chk("ovl_rise", int'(counting0), 1);
    idle(1005);
    chk("len_d0", len0, 1000);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    chk("abort_wait", int'(done0), 1);
    step(1'b0, 1'b1, 1'b0);
    chk("ack_ovl", int'(done0), 0);

    // Second configuration: 10110 + 010, auto-rearm, then restart without ack.
    len0 = 0; len1 = 0; dcyc1 = 0;
    send(16'h0016, 5);
    send(16'h0002, 3);
    idle(20);
    chk("len_p1", len1, 12);
    chk("pulse_p1", dcyc1, 1);
    chk("no_trig", len0, 0);
    send(16'h0016, 5);
    send(16'h0000, 3);
    idle(10);
    chk("len_p1b", len1, 16);
    chk("pulse_p1b", dcyc1, 2);

    // Abort at count=2; ack during counting has no effect.
    dcyc0 = 0;
    send(16'h00D3, 8);
    idle(1500);
    chk("abt_cnt2", int'(count0), 2);
    repeat (2) step(1'b0, 1'b1, 1'b0);
    chk("ack_cnt", int'(counting0), 1);
    step(1'b0, 1'b0, 1'b1);
    chk("abt_counting", int'(counting0), 0);
    chk("abt_count", int'(count0), 0);
    idle(3000);
    chk("abt_nodone", dcyc0, 0);
    send(16'h0005, 4);
    idle(10);
    chk("abt_norestart", int'(counting0), 0);
    send(16'h00D0, 8);
    idle(1005);
    chk("abt_restart", int'(done0), 1);
    step(1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-count.
    send(16'h00D2, 8);
    idle(500);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("arst");
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    len0 = 0;
    send(16'h00D1, 8);
    idle(2005);
    chk("arst_len", len0, 2000);
    chk("arst_done", int'(done0), 1);
    step(1'b0, 1'b1, 1'b0);

    // Random traffic against the model.
    for (int k = 0; k < 20000; k++) begin
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1999) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pattern_timer_fsm.md
Name: pattern_timer_fsm

Overview:
- Parametrised successor to the serial "start-pattern → delay → count → done/ack" timer FSM.
- Hunts a serial `data` stream for a configurable start pattern, then shifts in a DELAY_W-bit delay value MSB-first.
- Counts (delay+1)·UNIT_CYCLES clocks, then holds `done` until acknowledged.
- Adds an abort input and an optional auto-rearm mode; sits between the serial front-end and the host handshake logic.

Parameters:
- PAT_LEN, 4, start-pattern length in bits (2..16).
- PATTERN, 4'b1101, start pattern; MSB is the first bit received; width PAT_LEN.
- DELAY_W, 4, width of the delay field and of `count` (1..16).
- UNIT_CYCLES, 1000, clocks per delay unit (≥1).
- AUTO_REARM, 0, 1 = skip WAIT_ACK: pulse `done` for one cycle and return to SEARCH.

Ports:
- clk, in, 1, system clock; rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- data, in, 1, serial input, sampled every rising edge.
- ack, in, 1, host acknowledge of `done`.
- abort, in, 1, cancels SHIFT/COUNT; synchronous.
- count, out, DELAY_W, remaining whole units while counting; 0 otherwise.
- counting, out, 1, high throughout COUNT.
- done, out, 1, high in WAIT_ACK; one-cycle pulse when AUTO_REARM=1.

Behaviour:
- Reset (reset_n=0, takes effect immediately):
  - state=SEARCH; pattern history, delay register and unit counter cleared.
  - count=0, counting=0, done=0.
  - Reset asserted mid-operation aborts everything; no partial result survives.
- States are SEARCH, SHIFT, COUNT and WAIT_ACK; all outputs are registered/Moore.
- SEARCH:
  - A PAT_LEN-bit history register shifts `data` in at its LSB every edge.
  - Match test is on {history[PAT_LEN-2:0], data] == PATTERN, so overlapping prefixes are detected (e.g. 1,1,1,0,1 matches 1101).
  - On the match edge E0 the next state is SHIFT.
  - History is cleared on every entry to SEARCH, so all pattern bits must arrive after re-entry.
- SHIFT:
  - Edges E1..E_DELAY_W sample `data` into the delay register, MSB first.
  - After edge E_DELAY_W: state=COUNT, count=delay value, unit counter=UNIT_CYCLES-1, counting=1.
- COUNT:
  - Unit counter decrements every clock.
  - When the unit counter is 0 and count>0: count decrements and the unit counter reloads to UNIT_CYCLES-1.
  - When the unit counter is 0 and count==0: the next state is WAIT_ACK (or SEARCH if AUTO_REARM=1).
  - counting stays high for exactly (delay+1)·UNIT_CYCLES cycles.
  - delay=0 yields UNIT_CYCLES cycles.
  - UNIT_CYCLES=1 is legal: count steps every clock.
- WAIT_ACK:
  - done=1, count=0, counting=0.
  - ack=1 sampled → next state SEARCH, done=0 the following cycle.
  - `data` is ignored here.
- AUTO_REARM=1: done=1 for exactly one cycle, coinciding with the first SEARCH cycle after COUNT; `ack` is ignored.
- ack outside WAIT_ACK has no effect; ack is not latched.
- abort:
  - Sampled high in SHIFT or COUNT → next state SEARCH, with count=0, counting=0 the next cycle, and done never asserts.
  - abort is ignored in SEARCH and WAIT_ACK.
  - If abort and final-count completion occur on the same edge, abort wins.
- Widths:
  - Unit counter width is $clog2(UNIT_CYCLES), minimum 1.
  - Nothing saturates or wraps; all arithmetic is unsigned.

Decomposition:
- Shared package `timer_pkg` holds:
  - the state enum (SEARCH, SHIFT, COUNT, WAIT_ACK; 2-bit encoding);
  - the localparam helper for unit-counter width.
- One sub-module, `unit_down_counter`:
  - parametrised by LOAD_VALUE;
  - inputs: load, en;
  - outputs: zero flag, value;
  - used for the UNIT_CYCLES prescaler.
- The FSM, pattern history and delay shift register stay in the top module.

Test Plan:
- Defaults: reset_n low 20 ns → release. data=1,1,0,1,0,1,0,1 (delay=5) → counting rises the clock after the 8th bit and stays high 6000 cycles; count is 5,4,3,2,1,0, each held 1000 cycles; then done=1 and holds. Hold ack=0 for 400 cycles → done stays 1. Pulse ack → done=0 the next cycle, state SEARCH.
- Overlap/false-start: data=1,1,1,0,1 then delay 0,0,0,0 → detection on the 5th bit; counting lasts 1000 cycles with count=0. The stream 1,0,1,1,0 alone never triggers.
- Abort: start with delay=3; assert abort at count=2 → counting=0 and count=0 the next cycle, done never rises; a fresh 1101 is then required to restart.
- Async reset mid-count: drop reset_n between clock edges → all outputs 0 immediately, not waiting for clk. After release, 1101 plus delay runs a full fresh count.
- Params PAT_LEN=5, PATTERN=5'b10110, DELAY_W=3, UNIT_CYCLES=4, AUTO_REARM=1: send 10110 then 010 → counting for 12 cycles, done pulses for 1 cycle, and a second pattern restarts without ack.
- ack while counting and abort while in WAIT_ACK → no effect on state or outputs.
